// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - prioritised multi-cause trap controller (optional per-cause counters: TRAP_CAUSE_CNT_EN)
module trap_ctrl #(
    parameter int NUM_CAUSES   = 4,
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int VECTORED     = 0,
    localparam int CW          = $clog2(NUM_CAUSES)
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       EN,
    input  logic [NUM_CAUSES-1:0]      CAUSE_VLD,
    input  logic [NUM_CAUSES*XLEN-1:0] CAUSE_TVAL,
    input  logic [XLEN-1:0]            CAUSE_PC,
    input  logic [XLEN-1:0]            MTVEC,
    input  logic                       MRET_DETECTED,
    output logic                       FLUSH,
    output logic                       REDIRECT_VLD,
    output logic [XLEN-1:0]            REDIRECT_PC,
    output logic                       TRAP_TAKEN,
    output logic [CW-1:0]              MCAUSE,
    output logic [XLEN-1:0]            MEPC,
    output logic [XLEN-1:0]            MTVAL,
    output logic                       EXECUTE_MRET,
    output logic                       BUSY,
    output logic                       DOUBLE_FAULT
`ifdef TRAP_CAUSE_CNT_EN
    ,
    input  logic [CW-1:0]              CNT_SEL,
    output logic [15:0]                CNT_VALUE
`endif
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FLUSH    = 3'd1;
    localparam logic [2:0] S_REDIRECT = 3'd2;
    localparam logic [2:0] S_HANDLER  = 3'd3;
    localparam logic [2:0] S_RETURN   = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [3:0]      fcnt_q, fcnt_d;
    logic [CW-1:0]   mcause_q;
    logic [XLEN-1:0] mepc_q, mtval_q;
    logic            flush_q, rvld_q, taken_q, emret_q, busy_q, df_q;
    logic [XLEN-1:0] rpc_q, rpc_d;
    logic            accept, df_set;
    logic [CW-1:0]   win_idx;
    logic [XLEN-1:0] win_tval;
    logic [XLEN-1:0] vec_off, handler_pc;

    // Fixed priority pick: the lowest-indexed pending request wins
    always_comb begin
        win_idx  = '0;
        win_tval = '0;
        for (int i = NUM_CAUSES - 1; i >= 0; i--) begin
            if (CAUSE_VLD[i]) begin
                win_idx  = CW'(i);
                win_tval = CAUSE_TVAL[i*XLEN +: XLEN];
            end
        end
    end

    // Handler target: aligned base, plus a 4-byte slot per cause in vectored mode
    always_comb begin
        vec_off    = (VECTORED != 0) ? (XLEN'(mcause_q) << 2) : '0;
        handler_pc = (MTVEC & ~XLEN'(3)) + vec_off;
    end

    // Next-state logic and flush countdown
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        accept  = 1'b0;
        df_set  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (EN && (|CAUSE_VLD)) begin
                    state_d = S_FLUSH;
                    fcnt_d  = 4'(FLUSH_CYCLES - 1);
                    accept  = 1'b1;
                end
            end
            S_FLUSH: begin
                if (fcnt_q == 4'd0) state_d = S_REDIRECT;
                else                fcnt_d  = fcnt_q - 4'd1;
            end
            S_REDIRECT: state_d = S_HANDLER;
            S_HANDLER: begin
                if (MRET_DETECTED)                state_d = S_RETURN;
                else if (EN && (|CAUSE_VLD))      df_set  = 1'b1;
            end
            S_RETURN: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Redirect target registered alongside the strobe that qualifies it
    always_comb begin
        rpc_d = '0;
        if (state_d == S_REDIRECT)    rpc_d = handler_pc;
        else if (state_d == S_RETURN) rpc_d = mepc_q;
    end

    // State, capture registers and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            fcnt_q   <= '0;
            mcause_q <= '0;
            mepc_q   <= '0;
            mtval_q  <= '0;
            flush_q  <= 1'b0;
            rvld_q   <= 1'b0;
            rpc_q    <= '0;
            taken_q  <= 1'b0;
            emret_q  <= 1'b0;
            busy_q   <= 1'b0;
            df_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            if (accept) begin
                mcause_q <= win_idx;
                mepc_q   <= CAUSE_PC;
                mtval_q  <= win_tval;
            end
            flush_q <= (state_d == S_FLUSH);
            rvld_q  <= (state_d == S_REDIRECT) || (state_d == S_RETURN);
            rpc_q   <= rpc_d;
            taken_q <= (state_d == S_REDIRECT);
            emret_q <= (state_d == S_RETURN);
            busy_q  <= (state_d != S_IDLE);
            if (df_set) df_q <= 1'b1;
        end
    end

    assign FLUSH        = flush_q;
    assign REDIRECT_VLD = rvld_q;
    assign REDIRECT_PC  = rpc_q;
    assign TRAP_TAKEN   = taken_q;
    assign MCAUSE       = mcause_q;
    assign MEPC         = mepc_q;
    assign MTVAL        = mtval_q;
    assign EXECUTE_MRET = emret_q;
    assign BUSY         = busy_q;
    assign DOUBLE_FAULT = df_q;

`ifdef TRAP_CAUSE_CNT_EN
    logic [15:0] cnt_q [NUM_CAUSES];

    // Per-cause saturating acceptance counters
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_CAUSES; i++) begin
            if (RST)
                cnt_q[i] <= '0;
            else if (accept && (win_idx == CW'(i)) && (cnt_q[i] != 16'hFFFF))
                cnt_q[i] <= cnt_q[i] + 16'd1;
        end
    end

    // Counter read port; an index with no counter behind it reads 0
    always_comb begin
        CNT_VALUE = '0;
        for (int i = 0; i < NUM_CAUSES; i++) begin
            if (CNT_SEL == CW'(i)) CNT_VALUE = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - directed self-checking bench for trap_ctrl (direct and vectored instances)
module tb_trap_ctrl;

    localparam int NC = 4;
    localparam int XL = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [NC-1:0]   cause_vld;
    logic [NC*XL-1:0] cause_tval;
    logic [XL-1:0]   cause_pc;
    logic [XL-1:0]   mtvec;
    logic            mret;

    logic            d_flush, d_rvld, d_taken, d_emret, d_busy, d_df;
    logic [XL-1:0]   d_rpc, d_mepc, d_mtval;
    logic [1:0]      d_mcause;
    logic            v_flush, v_rvld, v_taken, v_emret, v_busy, v_df;
    logic [XL-1:0]   v_rpc, v_mepc, v_mtval;
    logic [1:0]      v_mcause;
`ifdef TRAP_CAUSE_CNT_EN
    logic [1:0]      cnt_sel;
    logic [15:0]     d_cnt, v_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trap_ctrl #(.NUM_CAUSES(NC), .XLEN(XL), .FLUSH_CYCLES(2), .VECTORED(0)) u_dut_d (
        .CLK(clk), .RST(rst), .EN(en), .CAUSE_VLD(cause_vld), .CAUSE_TVAL(cause_tval),
        .CAUSE_PC(cause_pc), .MTVEC(mtvec), .MRET_DETECTED(mret),
        .FLUSH(d_flush), .REDIRECT_VLD(d_rvld), .REDIRECT_PC(d_rpc), .TRAP_TAKEN(d_taken),
        .MCAUSE(d_mcause), .MEPC(d_mepc), .MTVAL(d_mtval), .EXECUTE_MRET(d_emret),
        .BUSY(d_busy), .DOUBLE_FAULT(d_df)
`ifdef TRAP_CAUSE_CNT_EN
        , .CNT_SEL(cnt_sel), .CNT_VALUE(d_cnt)
`endif
    );

    trap_ctrl #(.NUM_CAUSES(NC), .XLEN(XL), .FLUSH_CYCLES(2), .VECTORED(1)) u_dut_v (
        .CLK(clk), .RST(rst), .EN(en), .CAUSE_VLD(cause_vld), .CAUSE_TVAL(cause_tval),
        .CAUSE_PC(cause_pc), .MTVEC(mtvec), .MRET_DETECTED(mret),
        .FLUSH(v_flush), .REDIRECT_VLD(v_rvld), .REDIRECT_PC(v_rpc), .TRAP_TAKEN(v_taken),
        .MCAUSE(v_mcause), .MEPC(v_mepc), .MTVAL(v_mtval), .EXECUTE_MRET(v_emret),
        .BUSY(v_busy), .DOUBLE_FAULT(v_df)
`ifdef TRAP_CAUSE_CNT_EN
        , .CNT_SEL(cnt_sel), .CNT_VALUE(v_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_trap(input logic [NC-1:0] vld);
        cause_vld = vld;
        tick();
        cause_vld = '0;
        tick(); tick(); tick();
        mret = 1'b1;
        tick();
        mret = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; cause_vld = '0; cause_tval = '0;
        cause_pc = '0; mtvec = '0; mret = 1'b0;
`ifdef TRAP_CAUSE_CNT_EN
        cnt_sel = '0;
`endif
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_flush", d_flush, 0);
        check("rst_rvld", d_rvld, 0);
        check("rst_rpc", d_rpc, 0);
        check("rst_busy", d_busy, 0);
        check("rst_mcause", d_mcause, 0);
        check("rst_df", d_df, 0);

        // Single request on channel 2; EN dropped mid-sequence must not abort
        cause_tval[2*XL +: XL] = 32'hDEAD_BEEF;
        cause_tval[1*XL +: XL] = 32'hCAFE_0001;
        cause_pc = 32'h100;
        mtvec    = 32'h803;
        cause_vld = 4'b0100;
        tick();
        cause_vld = '0;
        en = 1'b0;
        check("t1_flush1", d_flush, 1);
        check("t1_busy", d_busy, 1);
        check("t1_mcause", d_mcause, 2);
        check("t1_mepc", d_mepc, 32'h100);
        check("t1_mtval", d_mtval, 32'hDEAD_BEEF);
        tick();
        check("t1_flush2", d_flush, 1);
        check("t1_rvld_early", d_rvld, 0);
        tick();
        check("t1_flush_off", d_flush, 0);
        check("t1_rvld", d_rvld, 1);
        check("t1_taken", d_taken, 1);
        check("t1_rpc_direct", d_rpc, 32'h800);
        check("t1_rpc_vec", v_rpc, 32'h808);
        tick();
        en = 1'b1;
        check("t1_hnd_rvld", d_rvld, 0);
        check("t1_hnd_taken", d_taken, 0);
        check("t1_hnd_busy", d_busy, 1);
        mret = 1'b1;
        tick();
        mret = 1'b0;
        check("t1_ret_rvld", d_rvld, 1);
        check("t1_ret_rpc", d_rpc, 32'h100);
        check("t1_ret_emret", d_emret, 1);
        tick();
        check("t1_idle_busy", d_busy, 0);
        check("t1_idle_emret", d_emret, 0);
        check("t1_hold_mcause", d_mcause, 2);

        // Two requests: channel 1 wins; then a fault inside the handler
        cause_vld = 4'b0110;
        tick();
        cause_vld = '0;
        check("t2_mcause", v_mcause, 1);
        check("t2_mtval", v_mtval, 32'hCAFE_0001);
        tick(); tick();
        check("t2_rpc_vec", v_rpc, 32'h804);
        check("t2_rpc_direct", d_rpc, 32'h800);
        tick();
        cause_vld = 4'b0001;
        tick();
        cause_vld = '0;
        check("t3_df_set", d_df, 1);
        check("t3_mcause_held", d_mcause, 1);
        mret = 1'b1;
        tick();
        mret = 1'b0;
        check("t3_df_ret", d_df, 1);
        tick();
        check("t3_df_idle", d_df, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t3_df_rst", d_df, 0);

        // Fault coincident with MRET: return wins, no double fault
        cause_vld = 4'b0001;
        tick();
        cause_vld = '0;
        tick(); tick(); tick();
        mret = 1'b1; cause_vld = 4'b0001;
        tick();
        mret = 1'b0; cause_vld = '0;
        check("t4_emret", d_emret, 1);
        check("t4_df", d_df, 0);
        tick();
        check("t4_df_idle", d_df, 0);
        check("t4_busy", d_busy, 0);

        // Reset in the middle of FLUSH abandons the sequence
        cause_vld = 4'b1000;
        tick();
        cause_vld = '0;
        check("t5_flush", d_flush, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_flush_rst", d_flush, 0);
        check("t5_busy_rst", d_busy, 0);
        check("t5_mepc_rst", d_mepc, 0);
        check("t5_mcause_rst", d_mcause, 0);
        tick(); tick();
        check("t5_no_redirect", d_rvld, 0);

        // Requests with EN low are ignored in IDLE
        en = 1'b0;
        cause_vld = 4'b1111;
        tick();
        check("t6_busy0", d_busy, 0);
        tick();
        check("t6_busy1", d_busy, 0);
        cause_vld = '0;
        en = 1'b1;

`ifdef TRAP_CAUSE_CNT_EN
        run_trap(4'b1000);
        run_trap(4'b1000);
        run_trap(4'b1000);
        cnt_sel = 2'd3;
        #1;
        check("cnt3", d_cnt, 3);
        cnt_sel = 2'd0;
        #1;
        check("cnt0", d_cnt, 0);
`else
        run_trap(4'b1000);
        check("t7_mcause", d_mcause, 3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
